// File: rtl/spu_pkg.sv
// spu_pkg: unit-id constants and result-entry layout helpers for the SPU result pipe
package spu_pkg;
   localparam logic [2:0] UNIT_PERM   = 3'b100;
   localparam logic [2:0] UNIT_LS     = 3'b101;
   localparam logic [2:0] UNIT_BRANCH = 3'b110;
   // entry = {unit_id, result, reg_dst, latency, reg_wr}, reg_wr in bit 0
   localparam int OFS_WR  = 0;
   localparam int OFS_LAT = 1;
   function automatic int entry_w(input int uw, input int dw, input int aw, input int lw);
      return uw + dw + aw + lw + 1;
   endfunction
   function automatic int ofs_dst(input int lw);
      return lw + 1;
   endfunction
   function automatic int ofs_res(input int aw, input int lw);
      return aw + lw + 1;
   endfunction
endpackage

// File: rtl/spu_fwd_lookup.sv
// spu_fwd_lookup: youngest-match forwarding lookup over the staged results for one query port
module spu_fwd_lookup #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int LAT_W  = 4,
   parameter int DEPTH  = 7
) (
   input  logic [DEPTH-1:0]        i_cand,
   input  logic [DEPTH*ADDR_W-1:0] i_dst,
   input  logic [DEPTH*LAT_W-1:0]  i_lat,
   input  logic [DEPTH*DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0]       i_addr,
   output logic                    o_hit,
   output logic                    o_pending,
   output logic [DATA_W-1:0]       o_data
);
   // scan oldest to youngest so the youngest match overwrites; the deepest stage is always ready
   always_comb begin
      o_hit = 1'b0;
      o_pending = 1'b0;
      o_data = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (i_cand[k] && i_dst[k*ADDR_W +: ADDR_W] == i_addr) begin
            o_hit = (k + 1 >= int'(i_lat[k*LAT_W +: LAT_W])) || (k == DEPTH - 1);
            o_pending = !o_hit;
            o_data = o_hit ? i_data[k*DATA_W +: DATA_W] : '0;
         end
      end
   end
endmodule

// File: rtl/spu_result_pipe.sv
// spu_result_pipe: DEPTH-stage result staging with flush, write-back and optional forwarding (SPU_RESULT_PIPE_FWD_EN)
module spu_result_pipe
   import spu_pkg::*;
#(
   parameter int DATA_W      = 128,
   parameter int ADDR_W      = 7,
   parameter int UNIT_W      = 3,
   parameter int LAT_W       = 4,
   parameter int DEPTH       = 7,
   parameter int FLUSH_DEPTH = 1,
   parameter int NUM_FWD     = 3,
   localparam int ENTRY_W    = entry_w(UNIT_W, DATA_W, ADDR_W, LAT_W)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [UNIT_W-1:0]          in_unit_id,
   input  logic [DATA_W-1:0]          in_result,
   input  logic [ADDR_W-1:0]          in_reg_dst,
   input  logic [LAT_W-1:0]           in_latency,
   input  logic                       in_reg_wr,
   input  logic                       flush,
   input  logic [NUM_FWD*ADDR_W-1:0]  fwd_addr,
   output logic [NUM_FWD-1:0]         fwd_hit,
   output logic [NUM_FWD-1:0]         fwd_pending,
   output logic [NUM_FWD*DATA_W-1:0]  fwd_data,
   output logic [DEPTH*ENTRY_W-1:0]   stage_packed,
   output logic [DEPTH-1:0]           stage_valid,
   output logic [ADDR_W-1:0]          wb_addr,
   output logic [DATA_W-1:0]          wb_data,
   output logic                       wb_en
);
   localparam int O_DST = ofs_dst(LAT_W);
   localparam int O_RES = ofs_res(ADDR_W, LAT_W);
   logic [ENTRY_W-1:0] r_stage [DEPTH];
   logic [DEPTH-1:0]   r_valid;
   logic [ADDR_W-1:0]  r_wb_addr;
   logic [DATA_W-1:0]  r_wb_data;
   logic               r_wb_en;
   logic [ENTRY_W-1:0] w_in;
   assign w_in = {in_unit_id, in_result, in_reg_dst, in_latency, in_reg_wr};
   // shift entries one stage per cycle, kill the flushed young window, retire the oldest to write-back
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
         r_valid   <= '0;
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else begin
         r_stage[0] <= w_in;
         r_valid[0] <= in_valid & ~flush;
         for (int k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
            r_valid[k] <= r_valid[k-1] & ~(flush & (k < FLUSH_DEPTH));
         end
         r_wb_en   <= r_valid[DEPTH-1] & r_stage[DEPTH-1][OFS_WR];
         r_wb_addr <= r_stage[DEPTH-1][O_DST +: ADDR_W];
         r_wb_data <= r_stage[DEPTH-1][O_RES +: DATA_W];
      end
   end
   for (genvar s = 0; s < DEPTH; s++) begin : g_pack
      assign stage_packed[s*ENTRY_W +: ENTRY_W] = r_stage[s];
   end
   assign stage_valid = r_valid;
   assign wb_en   = r_wb_en;
   assign wb_addr = r_wb_addr;
   assign wb_data = r_wb_data;
`ifdef SPU_RESULT_PIPE_FWD_EN
   logic [DEPTH-1:0]        w_cand;
   logic [DEPTH*ADDR_W-1:0] w_dst;
   logic [DEPTH*LAT_W-1:0]  w_lat;
   logic [DEPTH*DATA_W-1:0] w_data;
   for (genvar s = 0; s < DEPTH; s++) begin : g_fld
      assign w_cand[s] = r_valid[s] & r_stage[s][OFS_WR];
      assign w_dst[s*ADDR_W +: ADDR_W] = r_stage[s][O_DST +: ADDR_W];
      assign w_lat[s*LAT_W +: LAT_W]   = r_stage[s][OFS_LAT +: LAT_W];
      assign w_data[s*DATA_W +: DATA_W] = r_stage[s][O_RES +: DATA_W];
   end
   for (genvar p = 0; p < NUM_FWD; p++) begin : g_fwd
      spu_fwd_lookup #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .LAT_W  (LAT_W),
         .DEPTH  (DEPTH)
      ) u_fwd (
         .i_cand    (w_cand),
         .i_dst     (w_dst),
         .i_lat     (w_lat),
         .i_data    (w_data),
         .i_addr    (fwd_addr[p*ADDR_W +: ADDR_W]),
         .o_hit     (fwd_hit[p]),
         .o_pending (fwd_pending[p]),
         .o_data    (fwd_data[p*DATA_W +: DATA_W])
      );
   end
`else
   logic w_unused;
   assign w_unused    = ^fwd_addr;
   assign fwd_hit     = '0;
   assign fwd_pending = '0;
   assign fwd_data    = '0;
`endif
endmodule

// File: tb/tb_spu_result_pipe.sv
// tb_spu_result_pipe: randomized and directed checks of spu_result_pipe against a cycle-history reference model
module tb_spu_result_pipe;
   import spu_pkg::*;
   localparam int DW = 128, AW = 7, UW = 3, LW = 4, D = 7, FD = 3, NF = 3;
   localparam int EW = UW + DW + AW + LW + 1;
   localparam int NC = 512;
   localparam int CW = 384;
`ifdef SPU_RESULT_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, in_valid, in_reg_wr, flush;
   logic [UW-1:0] in_unit_id;
   logic [DW-1:0] in_result;
   logic [AW-1:0] in_reg_dst;
   logic [LW-1:0] in_latency;
   logic [NF*AW-1:0] fwd_addr;
   logic [NF-1:0] fwd_hit, fwd_pending;
   logic [NF*DW-1:0] fwd_data;
   logic [D*EW-1:0] stage_packed;
   logic [D-1:0] stage_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic wb_en;

   spu_result_pipe #(.FLUSH_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_unit_id(in_unit_id),
      .in_result(in_result), .in_reg_dst(in_reg_dst), .in_latency(in_latency),
      .in_reg_wr(in_reg_wr), .flush(flush), .fwd_addr(fwd_addr),
      .fwd_hit(fwd_hit), .fwd_pending(fwd_pending), .fwd_data(fwd_data),
      .stage_packed(stage_packed), .stage_valid(stage_valid),
      .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en)
   );

   int checks = 0, errors = 0, cyc = 0, wb_cnt = 0;
   logic [127:0] wb_seen;
   logic [AW-1:0] last_wb_addr;
   logic [DW-1:0] last_wb_data;
   logic h_v [NC], h_w [NC], h_f [NC], h_r [NC];
   logic [UW-1:0] h_u [NC];
   logic [DW-1:0] h_d [NC];
   logic [AW-1:0] h_a [NC];
   logic [LW-1:0] h_l [NC];

   // entry issued in cycle c0 is live after edge c unless its input was invalid, a reset followed, or a flush caught it within FD cycles
   function automatic bit alive(input int c0, input int c);
      if (c0 < 0 || !h_v[c0]) return 1'b0;
      for (int f = c0; f <= c; f++) if (h_r[f] || (h_f[f] && f - c0 < FD)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [EW-1:0] entry(input int c0, input int c);
      if (c0 < 0) return '0;
      for (int f = c0; f <= c; f++) if (h_r[f]) return '0;
      return {h_u[c0], h_d[c0], h_a[c0], h_l[c0], h_w[c0]};
   endfunction

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle(input int c);
      logic [D-1:0] ev;
      logic [EW-1:0] e;
      logic we;
      logic [NF-1:0] eh, ep;
      logic [NF*DW-1:0] ed;
      logic [AW-1:0] q;
      int c0, lat;
      for (int k = 1; k <= D; k++) begin
         ev[k-1] = alive(c - k + 1, c);
         chk($sformatf("stage%0d", k), CW'(stage_packed[(k-1)*EW +: EW]), CW'(entry(c - k + 1, c)));
      end
      chk("stage_valid", CW'(stage_valid), CW'(ev));
      e  = h_r[c] ? '0 : entry(c - D, c - 1);
      we = h_r[c] ? 1'b0 : (alive(c - D, c - 1) & e[0]);
      chk("wb_en", CW'(wb_en), CW'(we));
      chk("wb_addr", CW'(wb_addr), CW'(e[LW+1 +: AW]));
      chk("wb_data", CW'(wb_data), CW'(e[LW+AW+1 +: DW]));
      eh = '0; ep = '0; ed = '0;
      for (int p = 0; p < NF; p++) begin
         q = fwd_addr[p*AW +: AW];
         for (int k = 1; k <= D; k++) begin
            c0 = c - k + 1;
            if (FWD && alive(c0, c) && h_w[c0] && h_a[c0] == q) begin
               lat = (h_l[c0] == 0) ? 1 : int'(h_l[c0]);
               if (k >= lat || k == D) begin
                  eh[p] = 1'b1;
                  ed[p*DW +: DW] = h_d[c0];
               end else ep[p] = 1'b1;
               break;
            end
         end
      end
      chk("fwd_hit", CW'(fwd_hit), CW'(eh));
      chk("fwd_pending", CW'(fwd_pending), CW'(ep));
      chk("fwd_data", CW'(fwd_data), CW'(ed));
   endtask

   task automatic step(input logic v, input logic [UW-1:0] u, input logic [DW-1:0] d,
                       input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w,
                       input logic f, input logic r, input logic [NF*AW-1:0] q);
      if (cyc >= NC) begin
         $display("FAIL history_overflow cycles=%0d limit=%0d", cyc, NC);
         $fatal(1, "history overflow");
      end
      in_valid = v; in_unit_id = u; in_result = d; in_reg_dst = a;
      in_latency = l; in_reg_wr = w; flush = f; rst = r; fwd_addr = q;
      h_v[cyc] = v; h_u[cyc] = u; h_d[cyc] = d; h_a[cyc] = a;
      h_l[cyc] = l; h_w[cyc] = w; h_f[cyc] = f; h_r[cyc] = r;
      @(posedge clk);
      @(negedge clk);
      check_cycle(cyc);
      if (wb_en) begin
         wb_cnt++;
         wb_seen[wb_addr] = 1'b1;
         last_wb_addr = wb_addr;
         last_wb_data = wb_data;
      end
      cyc++;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [NF*AW-1:0] q3(input int a);
      return {NF{AW'(a)}};
   endfunction

   task automatic idle(input int n, input logic [NF*AW-1:0] q);
      for (int i = 0; i < n; i++)
         step(1'b0, UNIT_LS, rnd_data(), AW'($urandom_range(0, 7)), LW'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, q);
   endtask

   initial begin
      wb_seen = '0;
      // reset held two cycles with a valid input present
      step(1'b1, UNIT_PERM, rnd_data(), 7'd1, 4'd1, 1'b1, 1'b0, 1'b1, q3(1));
      step(1'b1, UNIT_PERM, rnd_data(), 7'd1, 4'd1, 1'b1, 1'b0, 1'b1, q3(1));
      chk("reset_valid", CW'(stage_valid), CW'(0));
      chk("reset_wb_en", CW'(wb_en), CW'(0));
      chk("reset_fwd_hit", CW'(fwd_hit), CW'(0));
      idle(2, q3(0));
      // pass-through of a single r5 result
      wb_cnt = 0;
      step(1'b1, UNIT_PERM, {16{8'hA5}}, 7'd5, 4'd2, 1'b1, 1'b0, 1'b0, q3(5));
      idle(D + 2, q3(5));
      chk("pt_wb_count", CW'(wb_cnt), CW'(1));
      chk("pt_wb_addr", CW'(last_wb_addr), CW'(5));
      chk("pt_wb_data", CW'(last_wb_data), CW'({16{8'hA5}}));
      // forwarding timing for r9 with latency 4
      step(1'b1, UNIT_LS, rnd_data(), 7'd9, 4'd4, 1'b1, 1'b0, 1'b0, q3(9));
      chk("fwd_t1_pending", CW'(fwd_pending), CW'(FWD ? 3'b111 : 3'b000));
      idle(3, q3(9));
      chk("fwd_t4_hit", CW'(fwd_hit), CW'(FWD ? 3'b111 : 3'b000));
      idle(6, q3(9));
      // youngest unready match blocks an older ready one
      step(1'b1, UNIT_PERM, DW'(128'h11), 7'd3, 4'd1, 1'b1, 1'b0, 1'b0, q3(3));
      step(1'b1, UNIT_BRANCH, DW'(128'h22), 7'd3, 4'd3, 1'b1, 1'b0, 1'b0, q3(3));
      chk("prio_pending", CW'(fwd_pending), CW'(FWD ? 3'b111 : 3'b000));
      chk("prio_hit", CW'(fwd_hit), CW'(0));
      idle(2, q3(3));
      chk("prio_late_data", CW'(fwd_data[DW-1:0]), CW'(FWD ? 128'h22 : 128'h0));
      idle(D, q3(3));
      // flush with the fifth of five back-to-back entries
      wb_seen = '0;
      for (int i = 0; i < 4; i++)
         step(1'b1, UNIT_LS, rnd_data(), AW'(10 + i), 4'd1, 1'b1, 1'b0, 1'b0, q3(10 + i));
      step(1'b1, UNIT_LS, rnd_data(), 7'd14, 4'd1, 1'b1, 1'b1, 1'b0, q3(12));
      idle(D + 3, q3(11));
      chk("flush_wb_seen", CW'(wb_seen[14:10]), CW'(5'b00011));
      // randomized traffic with occasional flushes and resets
      for (int i = 0; i < 250; i++)
         step($urandom_range(0, 3) != 0, UW'($urandom_range(4, 6)), rnd_data(),
              AW'($urandom_range(0, 7)), LW'($urandom_range(0, 15)), $urandom_range(0, 4) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
              {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))});
      // reset with a full pipe loses everything and issues no write-back
      for (int i = 0; i < D; i++)
         step(1'b1, UNIT_PERM, rnd_data(), AW'(20 + i), 4'd1, 1'b1, 1'b0, 1'b0, q3(20));
      step(1'b1, UNIT_PERM, rnd_data(), 7'd30, 4'd1, 1'b1, 1'b0, 1'b1, q3(20));
      chk("midrst_wb_en0", CW'(wb_en), CW'(0));
      idle(1, q3(20));
      chk("midrst_wb_en1", CW'(wb_en), CW'(0));
      chk("midrst_valid", CW'(stage_valid), CW'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
